// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - fetch/LSU arbiter for a single-port memory
// One transaction outstanding at a time, with a watchdog that aborts a stuck transaction.
module miriscv_mem_arbiter #(
   parameter int         XLEN    = 32,
   parameter logic       ARB_RR  = 1'b1,
   parameter int         TIMEOUT = 255,
   parameter int         CNT_W   = 8
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              instr_req_i,
   input  logic [XLEN-1:0]   instr_addr_i,
   output logic              instr_rvalid_o,
   output logic [XLEN-1:0]   instr_rdata_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_rvalid_o,
   output logic [XLEN-1:0]   data_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   output logic              busy_o,
   output logic              bus_err_o
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic             LP_WDOG_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] LP_TMO_M1  = CNT_W'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_owner;
   logic             r_last_owner;
   logic [CNT_W-1:0] r_wdog;

   logic w_any_req;
   logic w_grant_data;
   logic w_busy;
   logic w_timeout;
   logic w_end;

   assign w_any_req = instr_req_i | data_req_i;
   assign w_busy    = (r_state == S_BUSY);

   // On a tie, round-robin hands the grant to whoever did not own the last transaction.
   always_comb begin
      w_grant_data = 1'b0;
      if (data_req_i && !instr_req_i)
         w_grant_data = 1'b1;
      else if (data_req_i && instr_req_i)
         w_grant_data = ARB_RR ? ~r_last_owner : 1'b1;
   end

   // A real completion in the timeout cycle takes precedence over the abort.
   assign w_timeout = LP_WDOG_EN && w_busy && !mem_rvalid_i && (r_wdog == LP_TMO_M1);
   assign w_end     = w_busy && (mem_rvalid_i || w_timeout);

   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_wdog       <= '0;
      end else begin
         r_state <= w_next_state;
         if (!w_busy) begin
            if (w_any_req) begin
               r_owner <= w_grant_data;
               r_wdog  <= '0;
            end
         end else begin
            if (w_end)
               r_last_owner <= r_owner;
            if (!mem_rvalid_i && (r_wdog != {CNT_W{1'b1}}))
               r_wdog <= r_wdog + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next_state = S_BUSY;
         S_BUSY:  if (w_end)     w_next_state = S_IDLE;
         default:                w_next_state = S_IDLE;
      endcase
   end

   // Everything is held at zero while arstn_i is low, even before the reset edge lands.
   always_comb begin
      instr_rvalid_o = 1'b0;
      instr_rdata_o  = '0;
      data_rvalid_o  = 1'b0;
      data_rdata_o   = '0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_be_o       = '0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      busy_o         = 1'b0;
      bus_err_o      = 1'b0;
      if (arstn_i && w_busy) begin
         busy_o    = 1'b1;
         mem_req_o = 1'b1;
         bus_err_o = w_timeout;
         if (r_owner) begin
            mem_we_o      = data_we_i;
            mem_be_o      = data_be_i;
            mem_addr_o    = data_addr_i;
            mem_wdata_o   = data_wdata_i;
            data_rvalid_o = w_end;
            data_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
         end else begin
            mem_be_o       = '1;
            mem_addr_o     = instr_addr_i;
            instr_rvalid_o = w_end;
            instr_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
         end
      end
   end

endmodule
